// File: rtl/seg_scan_capture.sv
// Recovers per-digit values from a multiplexed active-low seven-segment bus.
// A digit is committed only after its {an, seg} sample has been stable long enough.
module seg_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic [2:0]            upd_index,
  output logic                  err
);

  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Returns {is_blank, is_digit, value}; neither flag set means an illegal glyph.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'b1000000: res = 6'b01_0000;
      7'b1111001: res = 6'b01_0001;
      7'b0100100: res = 6'b01_0010;
      7'b0110000: res = 6'b01_0011;
      7'b0011001: res = 6'b01_0100;
      7'b0010010: res = 6'b01_0101;
      7'b0000010: res = 6'b01_0110;
      7'b1111000: res = 6'b01_0111;
      7'b0000000: res = 6'b01_1000;
      7'b0010000: res = 6'b01_1001;
      7'b1111111: res = 6'b10_1111;
      default:    res = 6'b00_1111;
    endcase
    return res;
  endfunction

  function automatic logic is_onehot(input logic [DIGITS-1:0] a);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      ones = ones + {3'b000, a[i]};
    end
    return ones == 4'd1;
  endfunction

  function automatic logic [2:0] onehot_index(input logic [DIGITS-1:0] a);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      idx = a[i] ? 3'(i) : idx;
    end
    return idx;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [SW-1:0]       sample_r;
  logic [CW-1:0]       cnt_r;
  logic [SW-1:0]       sample_s;
  logic                same_s;
  logic                in_onehot_s;
  logic [DIGITS-1:0]   an_q_s;
  logic [5:0]          dec_s;
  logic                commit_s;
  logic                commit_digit_s;
  logic                commit_blank_s;
  logic                commit_err_s;
  logic [2:0]          commit_idx_s;

  assign sample_s    = {an_in, seg_in};
  assign same_s      = (sample_s == sample_r);
  assign in_onehot_s = is_onehot(an_in);
  assign an_q_s      = sample_r[SW-1:7];

  // Input sample register; reset value looks like an undriven, blank display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_r <= {{DIGITS{1'b0}}, 7'h7F};
    end else begin
      sample_r <= sample_s;
    end
  end

  // Stability counter: restarts on any sample change, saturates otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (!same_s || state_r == IDLE) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: any sample change re-arms settling (or parks in IDLE).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_onehot_s) state_nxt_s = SETTLE;
        else             state_nxt_s = IDLE;
      end
      SETTLE: begin
        if (!same_s)               state_nxt_s = in_onehot_s ? SETTLE : IDLE;
        else if (cnt_r == CNT_LAST) state_nxt_s = HOLD;
        else                        state_nxt_s = SETTLE;
      end
      HOLD: begin
        if (!same_s) state_nxt_s = in_onehot_s ? SETTLE : IDLE;
        else         state_nxt_s = HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Commit decode: classify the settled glyph for the selected digit.
  always_comb begin
    commit_s       = 1'b0;
    commit_digit_s = 1'b0;
    commit_blank_s = 1'b0;
    commit_err_s   = 1'b0;
    dec_s          = seg_decode(sample_r[6:0]);
    commit_idx_s   = onehot_index(an_q_s);
    if (state_r == SETTLE && same_s && cnt_r == CNT_LAST) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
    if (commit_s) begin
      commit_digit_s = dec_s[4];
      commit_blank_s = dec_s[5];
      commit_err_s   = !dec_s[4] && !dec_s[5];
    end else begin
      commit_digit_s = 1'b0;
      commit_blank_s = 1'b0;
      commit_err_s   = 1'b0;
    end
  end

  // Registered outputs; a commit touches only the digit selected in the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_out  <= {(4*DIGITS){1'b1}};
      digit_valid <= {DIGITS{1'b0}};
      update      <= 1'b0;
      err         <= 1'b0;
      upd_index   <= 3'd0;
    end else begin
      update <= commit_digit_s || commit_blank_s;
      err    <= commit_err_s;
      if (commit_s) begin
        upd_index <= commit_idx_s;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (commit_digit_s && an_q_s[i]) begin
          digits_out[4*i +: 4] <= dec_s[3:0];
          digit_valid[i]       <= 1'b1;
        end else if (commit_blank_s && an_q_s[i]) begin
          digits_out[4*i +: 4] <= 4'hF;
          digit_valid[i]       <= 1'b0;
        end
      end
    end
  end

  seg_scan_capture_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .update (update),
    .err    (err)
  );

endmodule

// Protocol checks for seg_scan_capture outputs.
module seg_scan_capture_chk (
  input logic clk,
  input logic rst,
  input logic update,
  input logic err
);

  // update and err report different outcomes of one commit and never coincide.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(update && err));
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scenarios plus random scan
// traffic, checked every cycle against a run-length reference model.
module tb_seg_scan_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [6:0]           seg_in = 7'h7F;
  logic [DIGITS-1:0]    an_in = '0;
  logic [4*DIGITS-1:0]  digits_out;
  logic [DIGITS-1:0]    digit_valid;
  logic                 update;
  logic [2:0]           upd_index;
  logic                 err;

  seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .digit_valid(digit_valid),
    .update(update), .upd_index(upd_index), .err(err)
  );

  always #5 clk = ~clk;

  logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

  int n_checks = 0;
  int n_pass   = 0;
  int upd_cnt  = 0;
  int err_cnt  = 0;

  // Reference model state
  logic [DIGITS+6:0] prev_m;
  int                run_m;
  logic [3:0]        val_m [DIGITS];
  logic [DIGITS-1:0] valid_m;
  logic              upd_m, err_m;
  logic [2:0]        idx_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    prev_m  = {{DIGITS{1'b0}}, 7'h7F};
    run_m   = 0;
    valid_m = '0;
    upd_m   = 1'b0;
    err_m   = 1'b0;
    idx_m   = 3'd0;
    for (int i = 0; i < DIGITS; i++) val_m[i] = 4'hF;
  endtask

  // One sampling edge: extend or restart the run; commit on the (STABLE+1)th equal sample.
  task automatic model_edge();
    logic [DIGITS+6:0] smp;
    int d;
    int pos;
    smp   = {an_in, seg_in};
    upd_m = 1'b0;
    err_m = 1'b0;
    if (smp == prev_m) begin
      if (run_m < 1000) run_m++;
    end else begin
      run_m  = 1;
      prev_m = smp;
    end
    if (run_m == STABLE + 1 && $countones(an_in) == 1) begin
      pos = 0;
      for (int i = 0; i < DIGITS; i++) if (an_in[i]) pos = i;
      d = -1;
      for (int k = 0; k < 10; k++) if (codes[k] == seg_in) d = k;
      idx_m = 3'(pos);
      if (d >= 0) begin
        val_m[pos] = 4'(d); valid_m[pos] = 1'b1; upd_m = 1'b1;
      end else if (seg_in == 7'h7F) begin
        val_m[pos] = 4'hF; valid_m[pos] = 1'b0; upd_m = 1'b1;
      end else begin
        err_m = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [4*DIGITS-1:0] exp_digits;
    for (int i = 0; i < DIGITS; i++) exp_digits[4*i +: 4] = val_m[i];
    chk("update", 32'(update), 32'(upd_m));
    chk("err", 32'(err), 32'(err_m));
    if (upd_m || err_m) chk("upd_index", 32'(upd_index), 32'(idx_m));
    chk("digits_out", 32'(digits_out), 32'(exp_digits));
    chk("digit_valid", 32'(digit_valid), 32'(valid_m));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    if (update) upd_cnt++;
    if (err) err_cnt++;
    check_outputs();
  endtask

  task automatic hold(input logic [DIGITS-1:0] a, input logic [6:0] s, input int n);
    an_in  = a;
    seg_in = s;
    repeat (n) step();
  endtask

  initial begin
    model_reset();
    repeat (2) step();
    #2 rst = 1'b0;
    chk("reset_digits", 32'(digits_out), 32'hFFFF);
    chk("reset_valid", 32'(digit_valid), 32'h0);

    // Single digit 2 on position 0: exactly one commit on the 5th sampling edge
    upd_cnt = 0;
    an_in = 4'b0001; seg_in = 7'b0100100;
    repeat (4) step();
    chk("t1_no_early_update", 32'(upd_cnt), 32'd0);
    step();
    chk("t1_update_5th_edge", 32'(update), 32'd1);
    repeat (10) step();
    chk("t1_update_once", 32'(upd_cnt), 32'd1);
    chk("t1_digits", 32'(digits_out), 32'h0000FFF2);
    chk("t1_valid", 32'(digit_valid), 32'b0001);

    // Scan 7,3,blank,9 twice
    upd_cnt = 0; err_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      hold(4'b0001, codes[7], 8);
      hold(4'b0010, codes[3], 8);
      hold(4'b0100, 7'h7F, 8);
      hold(4'b1000, codes[9], 8);
    end
    chk("scan_updates", 32'(upd_cnt), 32'd8);
    chk("scan_err", 32'(err_cnt), 32'd0);
    chk("scan_digits", 32'(digits_out), 32'h00009F37);
    chk("scan_valid", 32'(digit_valid), 32'b1011);

    // Short 8 then steady 1 on digit 2
    upd_cnt = 0;
    hold(4'b0100, 7'b0000000, 3);
    hold(4'b0100, 7'b1111001, 6);
    chk("glitch_updates", 32'(upd_cnt), 32'd1);
    chk("glitch_digit2", 32'(digits_out[11:8]), 32'd1);

    // Illegal glyph "A" on digit 1
    upd_cnt = 0; err_cnt = 0;
    hold(4'b0010, 7'b0001000, 12);
    chk("errA_count", 32'(err_cnt), 32'd1);
    chk("errA_no_update", 32'(upd_cnt), 32'd0);
    chk("errA_digits", 32'(digits_out), 32'h00009137);

    // Non-one-hot selects never commit
    upd_cnt = 0; err_cnt = 0;
    hold(4'b0011, codes[5], 20);
    hold(4'b0000, codes[6], 20);
    chk("multi_none_updates", 32'(upd_cnt + err_cnt), 32'd0);

    // Reset during settle of digit 3 showing 5
    hold(4'b1000, codes[5], 2);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    chk("midreset_digits", 32'(digits_out), 32'hFFFF);
    step();
    rst = 1'b0;
    upd_cnt = 0;
    repeat (4) step();
    chk("postreset_no_early", 32'(upd_cnt), 32'd0);
    step();
    chk("postreset_commit", 32'(update), 32'd1);
    chk("postreset_digit3", 32'(digits_out), 32'h5FFF);

    // Random scan traffic
    for (int n = 0; n < 80; n++) begin
      logic [DIGITS-1:0] a;
      logic [6:0] s;
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) a = '0;
      else if (r == 1) a = 4'b0101;
      else a = 4'(1 << $urandom_range(0, DIGITS - 1));
      r = int'($urandom_range(0, 19));
      if (r < 14) s = codes[$urandom_range(0, 9)];
      else if (r < 17) s = 7'h7F;
      else s = 7'($urandom);
      hold(a, s, int'($urandom_range(1, 8)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
